// File: rtl/mem_pkg.sv
// Shared definitions for the memory-stage load/store unit.
//   Size codes, FSM state encoding, the latched request payload and a
//   helper giving the byte count of an access size.
package mem_pkg;

    localparam int unsigned DWORD_W = 64;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_RESP = 2'd3
    } mau_state_t;

    // Request fields held for the duration of one transaction
    typedef struct packed {
        logic               we;
        logic [1:0]         size;
        logic               uns;
        logic [2:0]         off;
        logic [DWORD_W-1:0] wdata;
    } mau_req_t;

    // Number of bytes moved by an access of the given size (1, 2, 4, 8)
    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'(4'd1 << size);
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane alignment for the load/store unit.
//   dword    : doubleword read from memory
//   offset   : byte lane of the access inside the doubleword
//   size     : access size code
//   wdata    : right-aligned store data
//   uns      : zero-extend (1) or sign-extend (0) loads
//   merged   : dword with the addressed lanes replaced by wdata
//   load_val : addressed lanes shifted down and extended to 64 bits
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [DWORD_W-1:0] dword,
    input  logic [2:0]         offset,
    input  logic [1:0]         size,
    input  logic [DWORD_W-1:0] wdata,
    input  logic               uns,
    output logic [DWORD_W-1:0] merged,
    output logic [DWORD_W-1:0] load_val
);

    logic [DWORD_W-1:0] lane_mask;
    logic [DWORD_W-1:0] shifted;
    logic [5:0]         bit_off;

    assign bit_off = {offset, 3'b000};

    // Right-aligned mask covering the bytes touched by this size
    always_comb begin
        lane_mask = '0;
        case (size)
            SZ_B:    lane_mask = 64'h0000_0000_0000_00FF;
            SZ_H:    lane_mask = 64'h0000_0000_0000_FFFF;
            SZ_W:    lane_mask = 64'h0000_0000_FFFF_FFFF;
            default: lane_mask = '1;
        endcase
    end

    assign merged  = (dword & ~(lane_mask << bit_off)) | ((wdata & lane_mask) << bit_off);
    assign shifted = dword >> bit_off;

    // Keep 2^size bytes, then extend from the top kept bit
    always_comb begin
        load_val = shifted;
        case (size)
            SZ_B:    load_val = uns ? 64'(shifted[7:0])  : {{56{shifted[7]}},  shifted[7:0]};
            SZ_H:    load_val = uns ? 64'(shifted[15:0]) : {{48{shifted[15]}}, shifted[15:0]};
            SZ_W:    load_val = uns ? 64'(shifted[31:0]) : {{32{shifted[31]}}, shifted[31:0]};
            default: load_val = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit in front of a 64-bit data memory.
//   Pipeline side : req_* in, mau_stall / resp_* out
//   Memory side   : mem_* out (always full doubleword), mem_rdata / mem_stall_in in
// Sub-doubleword stores run as read-modify-write; loads are lane extracted
// and extended. Misaligned requests optionally trap without touching memory.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned XLEN          = 64,
    parameter bit          MISALIGN_TRAP = 1'b1
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            req_v,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            mau_stall,
    output logic            resp_v,
    output logic [XLEN-1:0] resp_data,
    output logic            resp_misaligned,
    output logic            mem_v,
    output logic            mem_we,
    output logic [1:0]      mem_size,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_stall_in,
    input  logic [XLEN-1:0] mem_rdata
);

    mau_state_t         state;
    mau_req_t           lat;
    logic [2:0]         low_mask;
    logic [2:0]         eff_off;
    logic               misaligned;
    logic [DWORD_W-1:0] merged;
    logic [DWORD_W-1:0] load_val;

    // Low address bits that must be zero for a naturally aligned access
    assign low_mask   = 3'(size_bytes(req_size) - 4'd1);
    assign misaligned = MISALIGN_TRAP && ((req_addr[2:0] & low_mask) != 3'd0);
    // Without trapping, stray low bits are dropped to force alignment
    assign eff_off    = req_addr[2:0] & ~low_mask;

    // Stall follows req_v while idle so the request is held until accepted
    always_comb begin
        mau_stall = 1'b0;
        if (!reset) begin
            case (state)
                ST_IDLE: mau_stall = req_v;
                ST_RD,
                ST_WR:   mau_stall = 1'b1;
                default: mau_stall = 1'b0;
            endcase
        end
    end

    mem_lane_align u_align (
        .dword    (mem_rdata),
        .offset   (lat.off),
        .size     (lat.size),
        .wdata    (lat.wdata),
        .uns      (lat.uns),
        .merged   (merged),
        .load_val (load_val)
    );

    // Transaction FSM; mem_wdata doubles as the read-modify-write buffer
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            lat             <= '0;
            resp_v          <= 1'b0;
            resp_data       <= '0;
            resp_misaligned <= 1'b0;
            mem_v           <= 1'b0;
            mem_we          <= 1'b0;
            mem_size        <= 2'd0;
            mem_addr        <= '0;
            mem_wdata       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_v) begin
                        lat.we    <= req_we;
                        lat.size  <= req_size;
                        lat.uns   <= req_unsigned;
                        lat.off   <= eff_off;
                        lat.wdata <= req_wdata;
                        if (misaligned) begin
                            state           <= ST_RESP;
                            resp_v          <= 1'b1;
                            resp_misaligned <= 1'b1;
                            resp_data       <= '0;
                        end else begin
                            mem_v    <= 1'b1;
                            mem_size <= SZ_D;
                            mem_addr <= {req_addr[XLEN-1:3], 3'b000};
                            if (req_we && req_size == SZ_D) begin
                                state     <= ST_WR;
                                mem_we    <= 1'b1;
                                mem_wdata <= req_wdata;
                            end else begin
                                state  <= ST_RD;
                                mem_we <= 1'b0;
                            end
                        end
                    end
                end
                ST_RD: begin
                    if (!mem_stall_in) begin
                        if (lat.we) begin
                            state     <= ST_WR;
                            mem_we    <= 1'b1;
                            mem_wdata <= merged;
                        end else begin
                            state     <= ST_RESP;
                            mem_v     <= 1'b0;
                            mem_size  <= 2'd0;
                            resp_v    <= 1'b1;
                            resp_data <= load_val;
                        end
                    end
                end
                ST_WR: begin
                    if (!mem_stall_in) begin
                        state     <= ST_RESP;
                        mem_v     <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_size  <= 2'd0;
                        resp_v    <= 1'b1;
                        resp_data <= '0;
                    end
                end
                default: begin
                    state           <= ST_IDLE;
                    resp_v          <= 1'b0;
                    resp_data       <= '0;
                    resp_misaligned <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a small doubleword memory model
// sits on the mem_* side; a byte-level reference model predicts results.
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        reset;
    logic        req_v;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        mau_stall;
    logic        resp_v;
    logic [63:0] resp_data;
    logic        resp_misaligned;
    logic        mem_v;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_stall_in;
    logic [63:0] mem_rdata;

    always #5 CLK = ~CLK;

    mem_access_unit #(.XLEN(64), .MISALIGN_TRAP(1'b1)) dut (
        .CLK             (CLK),
        .reset           (reset),
        .req_v           (req_v),
        .req_we          (req_we),
        .req_size        (req_size),
        .req_unsigned    (req_unsigned),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .mau_stall       (mau_stall),
        .resp_v          (resp_v),
        .resp_data       (resp_data),
        .resp_misaligned (resp_misaligned),
        .mem_v           (mem_v),
        .mem_we          (mem_we),
        .mem_size        (mem_size),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_stall_in    (mem_stall_in),
        .mem_rdata       (mem_rdata)
    );

    // Environment memory: 32 doublewords, combinational read, write on edge
    logic [63:0] env_mem  [32];
    logic [63:0] seed_mem [32];
    logic [63:0] ref_mem  [32];
    logic        mem_load;

    assign mem_rdata = env_mem[mem_addr[7:3]];

    always @(posedge CLK) begin
        if (mem_load) begin
            for (int i = 0; i < 32; i++) env_mem[i] <= seed_mem[i];
        end else if (mem_v && mem_we && !mem_stall_in) begin
            env_mem[mem_addr[7:3]] <= mem_wdata;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] last_data;
    logic [63:0] last_wdata;
    logic        last_mis;
    logic        last_rd;
    int          last_lat;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] s);
        return 1 << s;
    endfunction

    // Reference load: gather the addressed bytes, then extend
    function automatic logic [63:0] ref_load(input logic [1:0] s, input logic u, input logic [7:0] a);
        logic [63:0] dw;
        logic [63:0] v;
        int n;
        int off;
        dw  = ref_mem[a[7:3]];
        n   = nbytes(s);
        off = int'(a[2:0]);
        v   = '0;
        for (int b = 0; b < n; b++) v[8*b +: 8] = dw[8*(off+b) +: 8];
        if (!u && n < 8 && v[8*n-1]) begin
            for (int b = n; b < 8; b++) v[8*b +: 8] = 8'hFF;
        end
        return v;
    endfunction

    // Reference store: overwrite the addressed bytes with the low store bytes
    task automatic ref_store(input logic [1:0] s, input logic [7:0] a, input logic [63:0] wd);
        logic [63:0] dw;
        int n;
        int off;
        dw  = ref_mem[a[7:3]];
        n   = nbytes(s);
        off = int'(a[2:0]);
        for (int b = 0; b < n; b++) dw[8*(off+b) +: 8] = wd[8*b +: 8];
        ref_mem[a[7:3]] = dw;
    endtask

    // One full transaction with `stalls` cycles of memory back-pressure
    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [7:0] addr, input logic [63:0] wdata, input int stalls);
        int          n;
        int          exp_lat;
        int          cyc;
        int          left;
        logic        mis;
        logic        got;
        logic        saw_rd;
        logic        saw_mv;
        logic        exp_rd;
        logic [63:0] exp_data;
        logic [63:0] exp_addr;
        n        = nbytes(sz);
        mis      = (int'(addr) % n) != 0;
        exp_addr = {56'd0, addr[7:3], 3'b000};
        if (mis)                 exp_lat = 1;
        else if (we && n < 8)    exp_lat = 3 + stalls;
        else                     exp_lat = 2 + stalls;
        exp_data = (!mis && !we) ? ref_load(sz, uns, addr) : 64'd0;
        exp_rd   = !mis && !(we && n == 8);

        @(negedge CLK);
        req_v        = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = {56'd0, addr};
        req_wdata    = wdata;
        mem_stall_in = 1'($urandom_range(0, 1));
        #1 check("stall_on_req", 64'(mau_stall), 64'd1);
        @(posedge CLK);
        #1;
        req_v        = 1'b0;
        req_addr     = 64'($urandom);
        req_wdata    = {$urandom, $urandom};
        req_size     = 2'($urandom_range(0, 3));
        mem_stall_in = 1'b0;

        cyc    = 0;
        got    = 1'b0;
        saw_rd = 1'b0;
        saw_mv = 1'b0;
        left   = stalls;
        while (!got && cyc < 40) begin
            @(negedge CLK);
            cyc++;
            if (resp_v) begin
                got       = 1'b1;
                last_data = resp_data;
                last_mis  = resp_misaligned;
                check("stall_in_resp", 64'(mau_stall), 64'd0);
                check("memv_in_resp", 64'(mem_v), 64'd0);
            end else begin
                check("stall_busy", 64'(mau_stall), 64'd1);
                if (mem_v) begin
                    saw_mv = 1'b1;
                    if (!mem_we) saw_rd = 1'b1;
                    else         last_wdata = mem_wdata;
                    check("mem_addr", mem_addr, exp_addr);
                    check("mem_size", 64'(mem_size), 64'd3);
                    mem_stall_in = (left > 0);
                    if (left > 0) left--;
                end
            end
        end
        mem_stall_in = 1'b0;
        last_lat = cyc;
        last_rd  = saw_rd;

        check("resp_seen", 64'(got), 64'd1);
        if (got) begin
            check("latency", 64'(cyc), 64'(exp_lat));
            check("resp_data", last_data, exp_data);
            check("resp_mis", 64'(last_mis), 64'(mis));
            check("mem_v_used", 64'(saw_mv), 64'(!mis));
            check("rd_beat", 64'(saw_rd), 64'(exp_rd));
            @(negedge CLK);
            check("resp_pulse", 64'(resp_v), 64'd0);
        end
        if (we && !mis) ref_store(sz, addr, wdata);
        check("mem_content", env_mem[addr[7:3]], ref_mem[addr[7:3]]);
    endtask

    initial begin
        logic        found;
        logic        seen;
        logic        r_we;
        logic [1:0]  r_sz;
        logic [7:0]  r_addr;

        reset        = 1'b1;
        req_v        = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        mem_stall_in = 1'b0;
        mem_load     = 1'b1;
        for (int i = 0; i < 32; i++) seed_mem[i] = {$urandom, $urandom};
        seed_mem[1] = 64'h8877_6655_4433_2211;
        for (int i = 0; i < 32; i++) ref_mem[i] = seed_mem[i];

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_resp_v", 64'(resp_v), 64'd0);
        check("rst_stall", 64'(mau_stall), 64'd0);
        check("rst_mem_v", 64'(mem_v), 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_wdata", mem_wdata, 64'd0);
        check("rst_resp_data", resp_data, 64'd0);
        mem_load = 1'b0;
        reset    = 1'b0;
        @(negedge CLK);

        // Directed cases
        do_req(1'b0, 2'd0, 1'b0, 8'h0F, 64'd0, 0);
        check("lb_signed", last_data, 64'hFFFF_FFFF_FFFF_FF88);
        check("lb_lat", 64'(last_lat), 64'd2);
        do_req(1'b0, 2'd0, 1'b1, 8'h0F, 64'd0, 0);
        check("lbu", last_data, 64'h0000_0000_0000_0088);
        do_req(1'b1, 2'd1, 1'b0, 8'h0A, 64'h0000_0000_0000_BEEF, 0);
        check("sh_wdata", last_wdata, 64'h8877_6655_BEEF_2211);
        check("sh_lat", 64'(last_lat), 64'd3);
        do_req(1'b0, 2'd3, 1'b0, 8'h08, 64'd0, 0);
        check("ld_after_sh", last_data, 64'h8877_6655_BEEF_2211);
        do_req(1'b1, 2'd3, 1'b0, 8'h00, 64'h0123_4567_89AB_CDEF, 0);
        check("sd_no_rd", 64'(last_rd), 64'd0);
        check("sd_lat", 64'(last_lat), 64'd2);
        do_req(1'b0, 2'd2, 1'b0, 8'h06, 64'd0, 0);
        check("lw_mis_flag", 64'(last_mis), 64'd1);
        check("lw_mis_lat", 64'(last_lat), 64'd1);
        do_req(1'b0, 2'd3, 1'b0, 8'h08, 64'd0, 3);
        check("stall_lat", 64'(last_lat), 64'd5);
        check("stall_data", last_data, 64'h8877_6655_BEEF_2211);

        // Reset while a sub-doubleword store is in its write beat
        @(negedge CLK);
        req_v        = 1'b1;
        req_we       = 1'b1;
        req_size     = 2'd1;
        req_unsigned = 1'b0;
        req_addr     = 64'h0A;
        req_wdata    = 64'h1234;
        @(posedge CLK);
        #1 req_v = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            @(negedge CLK);
            if (mem_v && mem_we) found = 1'b1;
        end
        check("rst_reach_wr", 64'(found), 64'd1);
        reset = 1'b1;
        #1;
        check("arst_mem_v", 64'(mem_v), 64'd0);
        check("arst_mem_we", 64'(mem_we), 64'd0);
        check("arst_mem_addr", mem_addr, 64'd0);
        check("arst_mem_wdata", mem_wdata, 64'd0);
        check("arst_mem_size", 64'(mem_size), 64'd0);
        check("arst_stall", 64'(mau_stall), 64'd0);
        @(posedge CLK);
        @(negedge CLK);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (4) begin
            @(negedge CLK);
            if (resp_v || mem_v) seen = 1'b1;
        end
        check("arst_no_resp", 64'(seen), 64'd0);
        check("arst_mem_kept", env_mem[1], ref_mem[1]);
        do_req(1'b0, 2'd3, 1'b0, 8'h08, 64'd0, 0);
        check("post_rst_load", last_data, 64'h8877_6655_BEEF_2211);

        // Randomized traffic, mostly aligned
        for (int t = 0; t < 150; t++) begin
            r_we   = 1'($urandom_range(0, 1));
            r_sz   = 2'($urandom_range(0, 3));
            r_addr = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) r_addr = r_addr & ~8'(nbytes(r_sz) - 1);
            do_req(r_we, r_sz, 1'($urandom_range(0, 1)), r_addr,
                   {$urandom, $urandom}, int'($urandom_range(0, 3)));
        end

        for (int i = 0; i < 32; i++) check("final_mem", env_mem[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage load/store unit between the pipeline MEM stage and the 64-bit data memory file.
- Accepts one load/store per transaction and checks natural alignment.
- Sub-doubleword stores are done as read-modify-write with full-doubleword writes.
- Loads are byte-lane extracted and sign/zero extended; the pipeline is stalled until a one-cycle response.

Parameters:
- XLEN, 64, data/address width; only 64 is supported.
- MISALIGN_TRAP, 1: 1 = misaligned request returns resp_misaligned with no memory access; 0 = low address bits are ignored (access forced to natural alignment).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_v  input  1  MEM stage has a valid load/store.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = doubleword.
- req_unsigned  input  1  loads: 1 = zero-extend, 0 = sign-extend.
- req_addr  input  XLEN  byte address.
- req_wdata  input  XLEN  store data, right-aligned.
- mau_stall  output  1  pipeline must hold MEM stage.
- resp_v  output  1  one-cycle completion pulse.
- resp_data  output  XLEN  formatted load data; 0 for stores.
- resp_misaligned  output  1  valid with resp_v.
- mem_v  output  1  memory access valid (drives MEM_V).
- mem_we  output  1  memory write enable.
- mem_size  output  2  always 3 when mem_v = 1.
- mem_addr  output  XLEN  {addr[63:3], 3'b000}.
- mem_wdata  output  XLEN  full doubleword write data.
- mem_stall_in  input  1  memory not ready; hold the current access.
- mem_rdata  input  XLEN  combinational doubleword read at mem_addr.

Behaviour:
- Reset: state = IDLE. All outputs 0, including mem_addr and mem_wdata. Latched request and RMW buffer are cleared.
- Reset mid-operation aborts the transaction immediately. No write is issued after reset asserts, and no resp_v follows.
- States: IDLE, RD, WR, RESP.
- IDLE:
  - Request accepted when req_v = 1. Latch we, size, unsigned, addr, wdata.
  - Misaligned (MISALIGN_TRAP = 1): half with addr[0] ≠ 0, word with addr[1:0] ≠ 0, dword with addr[2:0] ≠ 0. Next state is RESP with the misaligned flag set.
  - Otherwise: load → RD; store size 3 → WR; store size < 3 → RD (RMW read).
  - mau_stall = req_v in IDLE (combinational).
- RD:
  - mem_v = 1, mem_we = 0.
  - While mem_stall_in = 1, hold all mem_* outputs stable.
  - When mem_stall_in = 0, capture mem_rdata into the buffer.
  - Load → RESP. Store → WR, with the merged doubleword written into the buffer.
  - Merge: lane offset = addr[2:0]. Bytes [off .. off+2^size-1] are replaced by the low bytes of wdata; other bytes are kept.
  - mau_stall = 1.
- WR:
  - mem_v = 1, mem_we = 1, mem_size = 3.
  - mem_wdata = merged buffer (size < 3) or latched wdata (size 3).
  - Write commits on the edge where mem_stall_in = 0, then → RESP. Hold while mem_stall_in = 1.
  - mau_stall = 1.
- RESP:
  - resp_v = 1 for exactly one cycle; mau_stall = 0; mem_v = 0; → IDLE.
  - resp_data = load result (loads), otherwise 0.
  - resp_misaligned is 1 only for a trapped request.
  - A req_v seen in the following IDLE cycle is a new request.
- Load format: shift the buffer right by 8*off and keep 2^size bytes. Sign-extend from the top kept bit unless unsigned. Size 3 passes through.
- Latency (mem_stall_in = 0, acceptance cycle = 0): resp_v asserts at cycle 2 for load and dword store, cycle 3 for sub-dword store, cycle 1 for misaligned. Each cycle of mem_stall_in = 1 adds one cycle.
- Misaligned requests never assert mem_v.
- mem_stall_in is ignored outside RD/WR.

Decomposition:
- Shared package mem_pkg: size constants SZ_B = 0, SZ_H = 1, SZ_W = 2, SZ_D = 3; state encoding; a function giving the byte count for a size.
- Sub-module mem_lane_align (combinational): inputs dword, offset, size, wdata, unsigned; outputs the merged dword and the extended load value. The FSM stays in mem_access_unit.

Test Plan:
- Memory dword at 0x8 = 0x8877665544332211; load byte, signed, addr 0xF → resp_v at cycle 2, resp_data = 0xFFFFFFFFFFFFFF88. Unsigned → 0x88.
- Same memory; store half 0xBEEF at 0xA → RD, then WR with mem_wdata = 0x88776655BEEF2211 and mem_size = 3. resp_v at cycle 3; a follow-up dword load returns that value.
- Store dword 0x0123456789ABCDEF at 0x0 → single WR cycle; resp_v at cycle 2; no RD beat observed.
- Load word at 0x6 with MISALIGN_TRAP = 1 → resp_v at cycle 1, resp_misaligned = 1, mem_v never asserted.
- Load with mem_stall_in = 1 for 3 cycles in RD → mem_addr and mem_v held stable; resp_v at cycle 5 with correct data.
- Assert reset during WR of a sub-dword store → all outputs 0 asynchronously, memory contents unchanged, no resp_v; the next request completes normally.
